// File: rtl/soc_pad_pkg.sv
// Shared definitions for the soc_pad_ctrl test-chip top: register offsets, FSM states, STATUS bits.
// Register offsets are relative to the register window at host address 0x8000.
package soc_pad_pkg;

    localparam logic [2:0] REG_LEN    = 3'd0;
    localparam logic [2:0] REG_SRC_A  = 3'd1;
    localparam logic [2:0] REG_SRC_B  = 3'd2;
    localparam logic [2:0] REG_DST    = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;
    localparam logic [2:0] REG_CYCLES = 3'd5;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_WR,
        ST_DONE
    } state_t;

endpackage

// File: rtl/soc_pad_spram.sv
// Single-port synchronous scratchpad, one-cycle registered read, read-before-write on collision.
module soc_pad_spram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/soc_pad_ctrl.sv
// Pad-level top: host scan access to scratchpad/registers and a vector-add kernel DST[i] = A[i] + B[i].
// Optional cycle counter register (0x8005) is built only when SOC_PAD_PERF_CNT_EN is defined.
module soc_pad_ctrl
    import soc_pad_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int MEM_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              chip_en,
    input  logic              data_addr_valid,
    input  logic              read_write,
    input  logic [ADDR_W-1:0] address_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    input  logic              scan_start_exec,
    input  logic              trigger,
    output logic              exec_end
);

    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam logic [DATA_W-1:0] ONE = 1;

    state_t            state;
    logic [DATA_W-1:0] len_r, src_a_r, src_b_r, dst_r, idx_r;
    logic [DATA_W-1:0] a_p1;
    logic [DATA_W-1:0] mem_rdata, mem_wdata, sum_w;
    logic [MEM_AW-1:0] mem_addr, addr_a, addr_b, addr_d;
    logic              mem_we;
    logic              busy, start, host_acc, is_reg, is_mem;
    logic [2:0]        reg_off;
    logic [DATA_W-1:0] reg_rdata, status_w;
    logic              vld_p1, resp_mem_p1;
    logic [DATA_W-1:0] reg_rd_p1, hold_r;

    assign busy     = (state == ST_RD_A) || (state == ST_RD_B) || (state == ST_WR);
    assign start    = trigger && chip_en && scan_start_exec && ((state == ST_IDLE) || (state == ST_DONE));
    assign host_acc = data_addr_valid && chip_en && !scan_start_exec && !busy;
    assign is_mem   = !address_in[ADDR_W-1];
    assign is_reg   = address_in[ADDR_W-1] && (address_in[ADDR_W-2:3] == '0);
    assign reg_off  = address_in[2:0];

    assign addr_a = src_a_r[MEM_AW-1:0] + idx_r[MEM_AW-1:0];
    assign addr_b = src_b_r[MEM_AW-1:0] + idx_r[MEM_AW-1:0];
    assign addr_d = dst_r[MEM_AW-1:0] + idx_r[MEM_AW-1:0];
    assign sum_w  = a_p1 + mem_rdata;

    // The FSM owns the memory port while busy; otherwise the host drives it
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = address_in[MEM_AW-1:0];
        mem_wdata = data_in;
        case (state)
            ST_RD_A: mem_addr = addr_a;
            ST_RD_B: mem_addr = addr_b;
            ST_WR: begin
                mem_we    = 1'b1;
                mem_addr  = addr_d;
                mem_wdata = sum_w;
            end
            default: mem_we = host_acc && is_mem && read_write;
        endcase
    end

    soc_pad_spram #(
        .DATA_W(DATA_W),
        .DEPTH (MEM_DEPTH),
        .AW    (MEM_AW)
    ) u_spram (
        .clk  (clk),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(mem_wdata),
        .rdata(mem_rdata)
    );

`ifdef SOC_PAD_PERF_CNT_EN
    logic [DATA_W-1:0] cycles_r;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cycles_r <= '0;
        end else if (start) begin
            cycles_r <= '0;
        end else if (busy && (cycles_r != '1)) begin
            cycles_r <= cycles_r + ONE;
        end
    end
`endif

    always_comb begin
        status_w = '0;
        status_w[STATUS_BUSY_BIT] = busy;
        status_w[STATUS_DONE_BIT] = (state == ST_DONE);
        reg_rdata = '0;
        if (is_reg) begin
            case (reg_off)
                REG_LEN:    reg_rdata = len_r;
                REG_SRC_A:  reg_rdata = src_a_r;
                REG_SRC_B:  reg_rdata = src_b_r;
                REG_DST:    reg_rdata = dst_r;
                REG_STATUS: reg_rdata = status_w;
`ifdef SOC_PAD_PERF_CNT_EN
                REG_CYCLES: reg_rdata = cycles_r;
`endif
                default:    reg_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            idx_r    <= '0;
            exec_end <= 1'b0;
            len_r    <= '0;
            src_a_r  <= '0;
            src_b_r  <= '0;
            dst_r    <= '0;
        end else begin
            if (host_acc && read_write && is_reg) begin
                case (reg_off)
                    REG_LEN:   len_r   <= data_in;
                    REG_SRC_A: src_a_r <= data_in;
                    REG_SRC_B: src_b_r <= data_in;
                    REG_DST:   dst_r   <= data_in;
                    default: ;
                endcase
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state    <= ST_RD_A;
                        idx_r    <= '0;
                        exec_end <= 1'b0;
                    end
                end
                ST_RD_A: begin
                    if (len_r == '0) begin
                        state    <= ST_DONE;
                        exec_end <= 1'b1;
                    end else begin
                        state <= ST_RD_B;
                    end
                end
                ST_RD_B: state <= ST_WR;
                ST_WR: begin
                    idx_r <= idx_r + ONE;
                    if (idx_r == len_r - ONE) begin
                        state    <= ST_DONE;
                        exec_end <= 1'b1;
                    end else begin
                        state <= ST_RD_A;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // p1: operand A captured while B is being read
    always_ff @(posedge clk) begin
        if (state == ST_RD_B) begin
            a_p1 <= mem_rdata;
        end
        if (host_acc && !read_write) begin
            reg_rd_p1 <= reg_rdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1      <= 1'b0;
            resp_mem_p1 <= 1'b0;
            hold_r      <= '0;
        end else begin
            vld_p1      <= host_acc && !read_write;
            resp_mem_p1 <= host_acc && !read_write && is_mem;
            hold_r      <= data_out;
        end
    end

    // Memory read data arrives straight from the RAM output register; data_out otherwise holds
    assign data_out       = vld_p1 ? (resp_mem_p1 ? mem_rdata : reg_rd_p1) : hold_r;
    assign data_out_valid = vld_p1;

endmodule

// File: tb/tb_soc_pad_ctrl.sv
// Directed self-checking bench for soc_pad_ctrl: scan access, vector-add runs, busy lockout, reset.
`timescale 1ns/1ps
module tb_soc_pad_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        chip_en = 1'b1;
    logic        data_addr_valid = 1'b0;
    logic        read_write = 1'b0;
    logic [15:0] address_in = '0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        data_out_valid;
    logic        scan_start_exec = 1'b0;
    logic        trigger = 1'b0;
    logic        exec_end;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    soc_pad_ctrl #(.DATA_W(16), .ADDR_W(16), .MEM_DEPTH(1024)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .chip_en        (chip_en),
        .data_addr_valid(data_addr_valid),
        .read_write     (read_write),
        .address_in     (address_in),
        .data_in        (data_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .scan_start_exec(scan_start_exec),
        .trigger        (trigger),
        .exec_end       (exec_end)
    );

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        data_addr_valid = 1'b1; read_write = 1'b1; address_in = a; data_in = d;
        @(negedge clk);
        data_addr_valid = 1'b0; read_write = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, output logic [15:0] d, output logic v);
        @(negedge clk);
        data_addr_valid = 1'b1; read_write = 1'b0; address_in = a;
        @(negedge clk);
        data_addr_valid = 1'b0;
        d = data_out;
        v = data_out_valid;
    endtask

    task automatic set_regs(input logic [15:0] sa, input logic [15:0] sb,
                            input logic [15:0] ds, input logic [15:0] ln);
        do_write(16'h8001, sa);
        do_write(16'h8002, sb);
        do_write(16'h8003, ds);
        do_write(16'h8000, ln);
    endtask

    // Returns the number of cycles from the start edge until exec_end is seen, -1 on timeout
    task automatic run_kernel(output int cyc);
        @(negedge clk);
        scan_start_exec = 1'b1; trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        cyc = 0;
        while (!exec_end && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200) cyc = -1;
        scan_start_exec = 1'b0;
    endtask

    task automatic test_reset;
        logic [15:0] d;
        logic        v;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (exec_end !== 1'b0 || data_out !== 16'h0 || data_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: exec_end=%b data_out=%h valid=%b want 0/0000/0", exec_end, data_out, data_out_valid);
        end
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_read(16'h8000 + 16'(i), d, v);
            checks++;
            if (d !== 16'h0 || v !== 1'b1) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h valid=%b want 0000 valid=1", i, d, v);
            end
        end
        @(negedge clk);
        checks++;
        if (data_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_pulse: valid=%b want 0", data_out_valid);
        end
    endtask

    task automatic test_scan;
        logic [15:0] d;
        logic        v;
        do_write(16'h0005, 16'h1234);
        do_read(16'h0005, d, v);
        checks++;
        if (d !== 16'h1234 || v !== 1'b1) begin
            errors++;
            $display("FAIL scan_mem5: got %h valid=%b want 1234 valid=1", d, v);
        end
        @(negedge clk);
        checks++;
        if (data_out !== 16'h1234 || data_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL data_hold: got %h valid=%b want 1234 valid=0", data_out, data_out_valid);
        end
        do_read(16'h9000, d, v);
        checks++;
        if (d !== 16'h0 || v !== 1'b1) begin
            errors++;
            $display("FAIL read_9000: got %h valid=%b want 0000 valid=1", d, v);
        end
        do_write(16'h8006, 16'hBEEF);
        do_read(16'h8006, d, v);
        checks++;
        if (d !== 16'h0) begin
            errors++;
            $display("FAIL unmapped_reg: got %h want 0000", d);
        end
        do_write(16'h8000, 16'h0055);
        do_read(16'h8000, d, v);
        checks++;
        if (d !== 16'h0055) begin
            errors++;
            $display("FAIL len_rw: got %h want 0055", d);
        end
        chip_en = 1'b0;
        do_write(16'h8000, 16'h0077);
        do_read(16'h8000, d, v);
        checks++;
        if (v !== 1'b0) begin
            errors++;
            $display("FAIL chip_en_off_read: valid=%b want 0", v);
        end
        chip_en = 1'b1;
        do_read(16'h8000, d, v);
        checks++;
        if (d !== 16'h0055) begin
            errors++;
            $display("FAIL chip_en_off_write: got %h want 0055", d);
        end
    endtask

    task automatic test_vec_add;
        logic [15:0] d;
        logic        v;
        int          cyc;
        logic [15:0] exp_sum [4] = '{16'd11, 16'd22, 16'd33, 16'd44};
        logic [15:0] exp_cyc;
        for (int i = 0; i < 4; i++) begin
            do_write(16'(i), 16'(i + 1));
            do_write(16'(16 + i), 16'(10 * (i + 1)));
        end
        set_regs(16'd0, 16'd16, 16'd32, 16'd4);
        run_kernel(cyc);
        checks++;
        if (cyc != 12) begin
            errors++;
            $display("FAIL vec_latency: got %0d cycles want 12", cyc);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(16'(32 + i), d, v);
            checks++;
            if (d !== exp_sum[i]) begin
                errors++;
                $display("FAIL vec_dst%0d: got %h want %h", i, d, exp_sum[i]);
            end
        end
        do_read(16'h8004, d, v);
        checks++;
        if (d !== 16'h0002 || exec_end !== 1'b1) begin
            errors++;
            $display("FAIL vec_status: got %h exec_end=%b want 0002 exec_end=1", d, exec_end);
        end
`ifdef SOC_PAD_PERF_CNT_EN
        exp_cyc = 16'd12;
`else
        exp_cyc = 16'd0;
`endif
        do_read(16'h8005, d, v);
        checks++;
        if (d !== exp_cyc) begin
            errors++;
            $display("FAIL cycles_reg: got %h want %h", d, exp_cyc);
        end
    endtask

    task automatic test_carry;
        logic [15:0] d;
        logic        v;
        int          cyc;
        do_write(16'd40, 16'hFFFF);
        do_write(16'd41, 16'h0002);
        set_regs(16'd40, 16'd41, 16'd42, 16'd1);
        run_kernel(cyc);
        checks++;
        if (cyc != 3) begin
            errors++;
            $display("FAIL carry_latency: got %0d cycles want 3", cyc);
        end
        do_read(16'd42, d, v);
        checks++;
        if (d !== 16'h0001) begin
            errors++;
            $display("FAIL carry_drop: got %h want 0001", d);
        end
    endtask

    task automatic test_wrap;
        logic [15:0] d;
        logic        v;
        int          cyc;
        logic [15:0] exp_sum [4] = '{16'd110, 16'd220, 16'd31, 16'd42};
        do_write(16'd1022, 16'd100);
        do_write(16'd1023, 16'd200);
        set_regs(16'd1022, 16'd16, 16'd48, 16'd4);
        run_kernel(cyc);
        checks++;
        if (cyc != 12) begin
            errors++;
            $display("FAIL wrap_latency: got %0d cycles want 12", cyc);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(16'(48 + i), d, v);
            checks++;
            if (d !== exp_sum[i]) begin
                errors++;
                $display("FAIL wrap_dst%0d: got %h want %h", i, d, exp_sum[i]);
            end
        end
    endtask

    task automatic test_len0;
        logic [15:0] d;
        logic        v;
        int          cyc;
        set_regs(16'd0, 16'd16, 16'd32, 16'd0);
        run_kernel(cyc);
        checks++;
        if (cyc != 1) begin
            errors++;
            $display("FAIL len0_latency: got %0d cycles want 1", cyc);
        end
        do_read(16'd32, d, v);
        checks++;
        if (d !== 16'd11) begin
            errors++;
            $display("FAIL len0_mem: got %h want 000b", d);
        end
    endtask

    task automatic test_busy;
        logic [15:0] d;
        logic        v;
        int          cnt;
        logic        seen_vld;
        do_write(16'd60, 16'h0000);
        do_write(16'd33, 16'h0000);
        set_regs(16'd0, 16'd16, 16'd32, 16'd4);
        @(negedge clk);
        scan_start_exec = 1'b1; trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        cnt = 0;
        seen_vld = 1'b0;
        while (!exec_end && cnt < 200) begin
            case (cnt)
                4: begin
                    scan_start_exec = 1'b0; data_addr_valid = 1'b1; read_write = 1'b1;
                    address_in = 16'd60; data_in = 16'hDEAD;
                end
                5: begin address_in = 16'h8000; data_in = 16'h0001; end
                6: begin read_write = 1'b0; address_in = 16'd60; end
                7: begin data_addr_valid = 1'b0; scan_start_exec = 1'b1; trigger = 1'b1; end
                8: trigger = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            cnt++;
            if (data_out_valid) seen_vld = 1'b1;
        end
        scan_start_exec = 1'b0; trigger = 1'b0; data_addr_valid = 1'b0;
        checks++;
        if (cnt != 12 || seen_vld !== 1'b0) begin
            errors++;
            $display("FAIL busy_run: cycles=%0d read_resp=%b want 12/0", cnt, seen_vld);
        end
        do_read(16'd60, d, v);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL busy_mem_write: got %h want 0000", d);
        end
        do_read(16'h8000, d, v);
        checks++;
        if (d !== 16'h0004) begin
            errors++;
            $display("FAIL busy_reg_write: got %h want 0004", d);
        end
        do_read(16'd33, d, v);
        checks++;
        if (d !== 16'd22) begin
            errors++;
            $display("FAIL busy_result: got %h want 0016", d);
        end
    endtask

    task automatic test_reset_midrun;
        logic [15:0] d;
        logic        v;
        int          cyc;
        logic [15:0] exp_sum [4] = '{16'd11, 16'd22, 16'd33, 16'd44};
        set_regs(16'd0, 16'd16, 16'd64, 16'd4);
        @(negedge clk);
        scan_start_exec = 1'b1; trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        repeat (5) @(negedge clk);
        scan_start_exec = 1'b0;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (exec_end !== 1'b0 || data_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: exec_end=%b valid=%b want 0/0", exec_end, data_out_valid);
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_read(16'h8000 + 16'(i), d, v);
            checks++;
            if (d !== 16'h0 || v !== 1'b1) begin
                errors++;
                $display("FAIL midrun_reg%0d: got %h valid=%b want 0000 valid=1", i, d, v);
            end
        end
        set_regs(16'd0, 16'd16, 16'd64, 16'd4);
        run_kernel(cyc);
        checks++;
        if (cyc != 12) begin
            errors++;
            $display("FAIL rerun_latency: got %0d cycles want 12", cyc);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(16'(64 + i), d, v);
            checks++;
            if (d !== exp_sum[i]) begin
                errors++;
                $display("FAIL rerun_dst%0d: got %h want %h", i, d, exp_sum[i]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_scan;
        test_vec_add;
        test_carry;
        test_wrap;
        test_len0;
        test_busy;
        test_reset_midrun;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
